npi_req_issue: RTL and testbench

Issue stage on the consumer side of the NPI address queue. Pops queued requests (RNW/Size/Addr/Id) from the address-path FIFO, drives the MPMC NPI address phase with a hold-until-ack handshake, and gates issue on PHY init and a read-outstanding limit. Records issued read Ids in an in-order tag FIFO so the read data path can label each completed burst with its originating Id.

---
 rtl/npi_req_issue_if.sv | 35 +++
 rtl/npi_req_issue.sv | 143 ++++++++++++++
 tb/tb_npi_req_issue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/npi_req_issue_if.sv
// NPI request-issue bundle: request-queue head, NPI address phase and read-tag reporting.
// The master modport is the issue stage and the slave modport is its environment.
interface npi_req_issue_if #(
    parameter int unsigned C_PI_ADDR_WIDTH = 32
);
    logic                       InitDone;
    logic                       ReqEmpty;
    logic                       ReqRNW;
    logic [3:0]                 ReqSize;
    logic [C_PI_ADDR_WIDTH-1:0] ReqAddr;
    logic [2:0]                 ReqId;
    logic                       ReqPop;
    logic                       PIM_AddrReq;
    logic                       PIM_RNW;
    logic [3:0]                 PIM_Size;
    logic [C_PI_ADDR_WIDTH-1:0] PIM_Addr;
    logic                       PIM_AddrAck;
    logic                       RdDone;
    logic [2:0]                 RdId;
    logic                       RdIdValid;
    logic [2:0]                 RdOutstanding;
    logic                       RdErr;

    modport master (
        input  InitDone, ReqEmpty, ReqRNW, ReqSize, ReqAddr, ReqId, PIM_AddrAck, RdDone,
        output ReqPop, PIM_AddrReq, PIM_RNW, PIM_Size, PIM_Addr,
               RdId, RdIdValid, RdOutstanding, RdErr
    );

    modport slave (
        output InitDone, ReqEmpty, ReqRNW, ReqSize, ReqAddr, ReqId, PIM_AddrAck, RdDone,
        input  ReqPop, PIM_AddrReq, PIM_RNW, PIM_Size, PIM_Addr,
               RdId, RdIdValid, RdOutstanding, RdErr
    );
endinterface

// File: rtl/npi_req_issue.sv
// NPI address-phase issue stage: pops queued requests, holds them until ack, limits
// outstanding reads and keeps an in-order Id FIFO for the read data path.
module npi_req_issue #(
    parameter int unsigned C_PI_ADDR_WIDTH      = 32,
    parameter int unsigned C_MAX_RD_OUTSTANDING = 4
) (
    input  logic            Clk,
    input  logic            Rst,
    npi_req_issue_if.master Bus
);
    localparam int unsigned ID_W   = 3;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PTR_W  = (C_MAX_RD_OUTSTANDING > 1) ? $clog2(C_MAX_RD_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_MAX_RD_OUTSTANDING - 1);
    localparam logic [CNT_W:0]   CNT_MAX  = (CNT_W + 1)'(C_MAX_RD_OUTSTANDING);

    typedef enum logic {IDLE, REQ} state_t;

    state_t                     state;
    state_t                     stateNxt;
    logic                       reqPop;
    logic                       issueOk;
    logic                       addrAck;
    logic [CNT_W:0]             rdCntEff;

    logic                       addrReqQ;
    logic                       rnwQ;
    logic [SIZE_W-1:0]          sizeQ;
    logic [C_PI_ADDR_WIDTH-1:0] addrQ;
    logic [ID_W-1:0]            pendIdQ;

    logic [ID_W-1:0]            tagMem [C_MAX_RD_OUTSTANDING];
    logic [PTR_W-1:0]           rdPtr;
    logic [PTR_W-1:0]           wrPtr;
    logic [PTR_W-1:0]           rdPtrNxt;
    logic [CNT_W-1:0]           rdCnt;
    logic [CNT_W-1:0]           rdCntNxt;
    logic                       tagPush;
    logic                       tagPop;
    logic [ID_W-1:0]            headNxt;
    logic [ID_W-1:0]            rdIdQ;
    logic                       rdIdValidQ;
    logic                       rdErrQ;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // A read still waiting for ack counts against the limit, so the ack cycle sees the post-push count
    assign rdCntEff = {1'b0, rdCnt} + (CNT_W + 1)'((state == REQ) && rnwQ);
    assign issueOk  = Bus.InitDone && !Bus.ReqEmpty && (!Bus.ReqRNW || (rdCntEff < CNT_MAX));
    assign addrAck  = (state == REQ) && Bus.PIM_AddrAck;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (issueOk) stateNxt = REQ;
            REQ:     if (Bus.PIM_AddrAck && !issueOk) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Pop only when the address slot is free or being freed by this cycle's ack
    always_comb begin
        reqPop = 1'b0;
        case (state)
            IDLE:    reqPop = issueOk;
            REQ:     reqPop = Bus.PIM_AddrAck && issueOk;
            default: reqPop = 1'b0;
        endcase
        if (Rst) reqPop = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            addrReqQ <= 1'b0;
            rnwQ     <= 1'b0;
            sizeQ    <= '0;
            addrQ    <= '0;
            pendIdQ  <= '0;
        end else if (reqPop) begin
            addrReqQ <= 1'b1;
            rnwQ     <= Bus.ReqRNW;
            sizeQ    <= Bus.ReqSize;
            addrQ    <= C_PI_ADDR_WIDTH'(Bus.ReqAddr);
            pendIdQ  <= Bus.ReqId;
        end else if (addrAck) begin
            addrReqQ <= 1'b0;
        end
    end

    assign tagPush  = addrAck && rnwQ;
    assign tagPop   = Bus.RdDone && (rdCnt != '0);
    assign rdCntNxt = rdCnt + CNT_W'(tagPush) - CNT_W'(tagPop);
    assign rdPtrNxt = tagPop ? ptrInc(rdPtr) : rdPtr;

    // Next head: bypass the Id being pushed when it becomes the head this same edge
    always_comb begin
        headNxt = '0;
        if (rdCntNxt != '0) begin
            if (tagPush && (rdPtrNxt == wrPtr)) headNxt = pendIdQ;
            else                                headNxt = tagMem[rdPtrNxt];
        end
    end

    always_ff @(posedge Clk) begin
        if (tagPush) tagMem[wrPtr] <= pendIdQ;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            rdCnt      <= '0;
            rdIdQ      <= '0;
            rdIdValidQ <= 1'b0;
            rdErrQ     <= 1'b0;
        end else begin
            if (tagPush) wrPtr <= ptrInc(wrPtr);
            rdPtr      <= rdPtrNxt;
            rdCnt      <= rdCntNxt;
            rdIdQ      <= headNxt;
            rdIdValidQ <= (rdCntNxt != '0);
            if (Bus.RdDone && (rdCnt == '0)) rdErrQ <= 1'b1;
        end
    end

    assign Bus.ReqPop        = reqPop;
    assign Bus.PIM_AddrReq   = addrReqQ;
    assign Bus.PIM_RNW       = rnwQ;
    assign Bus.PIM_Size      = sizeQ;
    assign Bus.PIM_Addr      = addrQ;
    assign Bus.RdId          = rdIdQ;
    assign Bus.RdIdValid     = rdIdValidQ;
    assign Bus.RdOutstanding = rdCnt;
    assign Bus.RdErr         = rdErrQ;
endmodule

// File: tb/tb_npi_req_issue.sv
// Randomized bench for npi_req_issue against a queue-based transaction model
// of the request source, the address phase and the outstanding-read Id list.
module tb_npi_req_issue;
    localparam int unsigned AW  = 32;
    localparam int unsigned MAX = 4;

    typedef struct {
        bit       rnw;
        bit [3:0] size;
        bit [31:0] addr;
        bit [2:0] id;
    } req_t;

    logic Clk = 1'b0;
    logic Rst;

    npi_req_issue_if #(.C_PI_ADDR_WIDTH(AW)) bus ();

    npi_req_issue #(
        .C_PI_ADDR_WIDTH     (AW),
        .C_MAX_RD_OUTSTANDING(MAX)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Bus(bus)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nPass   = 0;

    // Stimulus knobs, percentages
    int pRst, pInit, pGap, pAck, pDone;
    bit refill;

    // Reference model state
    req_t      srcQ[$];
    bit [2:0]  tagQ[$];
    bit        mReq, mRnw, mErr;
    bit [3:0]  mSize;
    bit [31:0] mAddr;
    bit [2:0]  mPendId;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic req_t randReq();
        req_t r;
        r.rnw  = 1'($urandom_range(1));
        r.size = 4'($urandom_range(15));
        r.addr = $urandom;
        r.id   = 3'($urandom_range(7));
        return r;
    endfunction

    task automatic setKnobs(input int r, input int i, input int g, input int a, input int d, input bit f);
        pRst = r; pInit = i; pGap = g; pAck = a; pDone = d; refill = f;
    endtask

    task automatic modelReset();
        mReq = 0; mRnw = 0; mSize = '0; mAddr = '0; mPendId = '0; mErr = 0;
        tagQ.delete();
    endtask

    task automatic step();
        req_t h;
        bit   empty, gap, ack, popExp;
        int   cntEff;
        @(negedge Clk);
        if (refill) while (srcQ.size() < 3) srcQ.push_back(randReq());
        Rst          = ($urandom_range(99) < pRst);
        bus.InitDone = ($urandom_range(99) < pInit);
        gap          = ($urandom_range(99) < pGap);
        empty        = (srcQ.size() == 0) || gap;
        h            = (srcQ.size() > 0) ? srcQ[0] : randReq();
        bus.ReqEmpty = empty;
        bus.ReqRNW   = h.rnw;
        bus.ReqSize  = h.size;
        bus.ReqAddr  = h.addr;
        bus.ReqId    = h.id;
        bus.PIM_AddrAck = ($urandom_range(99) < pAck);
        bus.RdDone      = ($urandom_range(99) < pDone);
        #1;
        checkEq("AddrReq",  bus.PIM_AddrReq, mReq);
        checkEq("RNW",      bus.PIM_RNW, mRnw);
        checkEq("Size",     bus.PIM_Size, mSize);
        checkEq("Addr",     bus.PIM_Addr, mAddr);
        checkEq("RdOutstanding", bus.RdOutstanding, tagQ.size());
        checkEq("RdIdValid", bus.RdIdValid, tagQ.size() > 0);
        checkEq("RdId",     bus.RdId, (tagQ.size() > 0) ? tagQ[0] : 3'd0);
        checkEq("RdErr",    bus.RdErr, mErr);
        // Reads waiting for ack occupy a slot just like completed-but-unretired ones
        ack    = mReq && bus.PIM_AddrAck;
        cntEff = tagQ.size() + ((mReq && mRnw) ? 1 : 0);
        popExp = !Rst && (!mReq || ack) && bus.InitDone && !empty && (!h.rnw || cntEff < MAX);
        checkEq("ReqPop", bus.ReqPop, popExp);
        @(posedge Clk);
        if (Rst) begin
            modelReset();
        end else begin
            if (bus.RdDone) begin
                if (tagQ.size() > 0) void'(tagQ.pop_front());
                else mErr = 1;
            end
            if (ack && mRnw) tagQ.push_back(mPendId);
            if (popExp) begin
                mReq = 1; mRnw = h.rnw; mSize = h.size; mAddr = h.addr; mPendId = h.id;
                void'(srcQ.pop_front());
            end else if (ack) begin
                mReq = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Rst = 1'b1;
        bus.InitDone = 1'b0; bus.ReqEmpty = 1'b1; bus.ReqRNW = 1'b0; bus.ReqSize = '0;
        bus.ReqAddr = '0; bus.ReqId = '0; bus.PIM_AddrAck = 1'b0; bus.RdDone = 1'b0;
        repeat (2) @(posedge Clk);
        modelReset();

        // Reset held with a ready queue, then free-running traffic
        setKnobs(100, 100, 0, 50, 0, 1); run(3);
        setKnobs(0, 90, 10, 60, 15, 1);  run(300);
        setKnobs(0, 50, 30, 30, 40, 1);  run(300);

        // Five reads with ack tied high: four issue, the fifth waits for a retirement
        setKnobs(100, 100, 0, 0, 0, 0);  run(2);
        srcQ.delete();
        for (int i = 0; i < 5; i++) srcQ.push_back('{rnw: 1'b1, size: 4'd2, addr: 32'(i * 64), id: 3'(i)});
        setKnobs(0, 100, 0, 100, 0, 0);  run(10);
        for (int i = 0; i < 6; i++) begin
            setKnobs(0, 100, 0, 100, 100, 0); run(1);
            setKnobs(0, 100, 0, 100, 0, 0);   run(1);
        end

        // Write held by InitDone low, then slow acks
        setKnobs(0, 100, 0, 100, 0, 0);
        srcQ.delete();
        srcQ.push_back('{rnw: 1'b0, size: 4'd4, addr: 32'h1000, id: 3'd0});
        setKnobs(0, 0, 0, 0, 0, 0);      run(10);
        setKnobs(0, 100, 0, 0, 0, 0);    run(3);
        setKnobs(0, 100, 0, 100, 0, 0);  run(2);

        // Occasional resets landing mid-request with reads outstanding
        setKnobs(4, 95, 5, 40, 10, 1);   run(300);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
